move_tracer: RTL and testbench
==============================

MOVE_TRACER -- requirements
Module: move_tracer

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the coordinate width in bits (grid 2^N x 2^N).
REQ-002 The block SHALL have parameter DIRECTION_SIZE, default 2, giving the move code width in bits.
REQ-003 Port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port RST  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  begins a trace from (0,0); sampled only in IDLE or DONE.
REQ-006 Port move_valid  input  1  move and move_last are valid this cycle.
REQ-007 Port move  input  DIRECTION_SIZE  move code: 00 = X+1, 01 = Y+1, 10 = X-1, 11 = Y-1.
REQ-008 Port move_last  input  1  the current move is the final move of the path.
REQ-009 Port move_ready  output  1  the block accepts a move this cycle.
REQ-010 Port map_addr  output  2N  maze cell address {Y, X} of the candidate cell.
REQ-011 Port map_data  input  1  combinational maze read of map_addr; 1 = wall, 0 = free.
REQ-012 Port X, Y  output  N each  current committed position.
REQ-013 Port step_count  output  8  number of moves committed in this trace.
REQ-014 Port busy, done, success, error  output  1 each  status flags.

Function
REQ-015 The FSM SHALL have four states, IDLE, WAIT_MOVE, CHECK and DONE, encoded in 2 bits.
REQ-016 In IDLE, or in DONE, with start = 1, the block SHALL set X = 0, Y = 0, step_count = 0, clear done, success and error, and go to WAIT_MOVE.
REQ-017 In WAIT_MOVE, move_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 A move SHALL be accepted when move_valid = 1 and move_ready = 1; the block SHALL latch move_last and the candidate position (X or Y plus or minus 1, N-bit).
REQ-019 If the candidate leaves the grid, the block SHALL set error = 1, leave X and Y unchanged, and go to DONE; it SHALL NOT wrap the position. This covers X = 2^N-1 with move 00, Y = 2^N-1 with move 01, X = 0 with move 10, and Y = 0 with move 11.
REQ-020 Otherwise the block SHALL go to CHECK and drive map_addr = {candY, candX} for the whole CHECK cycle.
REQ-021 In CHECK, if map_data = 1, the block SHALL set error = 1, leave X and Y unchanged, and go to DONE.
REQ-022 In CHECK, if map_data = 0, the block SHALL commit X and Y to the candidate and increment step_count.
  - If the latched move_last = 1: go to DONE with success = 1 iff the committed position is (2^N-1, 2^N-1), otherwise error = 1.
  - Otherwise: return to WAIT_MOVE.
REQ-023 When step_count = 255 and a commit occurs, the block SHALL set error = 1, hold step_count at 255, and go to DONE.
REQ-024 Latency SHALL be as follows: a move accepted in cycle t updates X and Y at the edge ending cycle t+1, and move_ready is reasserted in cycle t+2.
REQ-025 Throughput SHALL be one move per two cycles.
REQ-026 busy SHALL be 1 exactly in WAIT_MOVE and CHECK.
REQ-027 done SHALL be 1 exactly in DONE and hold until start or RST.
REQ-028 success and error SHALL never both be 1, and SHALL be valid whenever done = 1.
REQ-029 start SHALL be ignored in WAIT_MOVE and CHECK.
REQ-030 move_valid SHALL be ignored when move_ready = 0.
REQ-031 In DONE, X, Y and step_count SHALL hold their final values.
REQ-032 Outside CHECK, map_addr SHALL equal {Y, X}.

Reset
REQ-033 With RST = 1 at a rising edge, the block SHALL go to IDLE with X = 0, Y = 0, step_count = 0, and busy = done = success = error = move_ready = 0.
REQ-034 RST SHALL take priority over start and move_valid in the same cycle.
REQ-035 RST asserted in any state, including mid-trace in CHECK, SHALL abort the trace with no commit.

Verification
REQ-036 Scenario: empty map, N = 4, start, then 15 x 00 followed by 15 x 01 with move_last on the last move -> done = 1, success = 1, X = 15, Y = 15, step_count = 30.
REQ-037 Scenario: start, then move 10 at (0,0) -> error = 1 one cycle after acceptance, X = 0, Y = 0, step_count = 0, and map_addr is never driven with a wrapped cell.
REQ-038 Scenario: wall at cell {Y=0, X=1}, move 00 from (0,0) -> map_addr = 0x01 in CHECK, error = 1, position stays (0,0).
REQ-039 Scenario: move_valid held high continuously -> moves are accepted only in every other cycle, and each commit lands exactly 1 cycle after acceptance.
REQ-040 Scenario: RST pulsed during CHECK of move 3 -> next cycle is IDLE, with all outputs at their reset values and step_count = 0.
REQ-041 Scenario: path ends with move_last at (3,2) -> done = 1, success = 0, error = 1; a following start resets to (0,0) with flags cleared.

Source files
------------

// File: rtl/move_tracer.sv
// rtl/move_tracer.sv - traces a move stream across a 2^N x 2^N maze, checking bounds and walls
module move_tracer #(
    parameter int N              = 4,
    parameter int DIRECTION_SIZE = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      move_valid,
    input  logic [DIRECTION_SIZE-1:0] move,
    input  logic                      move_last,
    output logic                      move_ready,
    output logic [2*N-1:0]            map_addr,
    input  logic                      map_data,
    output logic [N-1:0]              X,
    output logic [N-1:0]              Y,
    output logic [7:0]                step_count,
    output logic                      busy,
    output logic                      done,
    output logic                      success,
    output logic                      error
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_MOVE = 2'd1,
        S_CHECK     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_y;
    logic [N-1:0]   r_cand_x;
    logic [N-1:0]   r_cand_y;
    logic [7:0]     r_step;
    logic           r_last;
    logic           r_success;
    logic           r_error;
    logic [N-1:0]   w_cand_x;
    logic [N-1:0]   w_cand_y;
    logic           w_off_grid;
    logic           w_step_max;
    logic           w_cand_corner;

    assign w_step_max    = (r_step == 8'hFF);
    assign w_cand_corner = (&r_cand_x) && (&r_cand_y);

    // Candidate position and the off-grid test are evaluated before any wrap can happen.
    always_comb begin
        w_cand_x   = r_x;
        w_cand_y   = r_y;
        w_off_grid = 1'b0;
        case (move[1:0])
            2'b00: begin w_cand_x = r_x + ONE; w_off_grid = &r_x;          end
            2'b01: begin w_cand_y = r_y + ONE; w_off_grid = &r_y;          end
            2'b10: begin w_cand_x = r_x - ONE; w_off_grid = (r_x == '0);   end
            default: begin w_cand_y = r_y - ONE; w_off_grid = (r_y == '0); end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next_state = S_WAIT_MOVE;
            S_WAIT_MOVE:    if (move_valid) w_next_state = w_off_grid ? S_DONE : S_CHECK;
            default: begin
                if (map_data || w_step_max || r_last) w_next_state = S_DONE;
                else                                  w_next_state = S_WAIT_MOVE;
            end
        endcase
    end

    always_comb begin
        move_ready = (r_state == S_WAIT_MOVE);
        busy       = (r_state == S_WAIT_MOVE) || (r_state == S_CHECK);
        done       = (r_state == S_DONE);
        map_addr   = (r_state == S_CHECK) ? {r_cand_y, r_cand_x} : {r_y, r_x};
        X          = r_x;
        Y          = r_y;
        step_count = r_step;
        success    = r_success;
        error      = r_error;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x       <= '0;
            r_y       <= '0;
            r_cand_x  <= '0;
            r_cand_y  <= '0;
            r_step    <= '0;
            r_last    <= 1'b0;
            r_success <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_x       <= '0;
                        r_y       <= '0;
                        r_step    <= '0;
                        r_success <= 1'b0;
                        r_error   <= 1'b0;
                    end
                end
                S_WAIT_MOVE: begin
                    if (move_valid) begin
                        r_last   <= move_last;
                        r_cand_x <= w_cand_x;
                        r_cand_y <= w_cand_y;
                        if (w_off_grid) r_error <= 1'b1;
                    end
                end
                default: begin
                    if (map_data) begin
                        r_error <= 1'b1;
                    end else begin
                        r_x <= r_cand_x;
                        r_y <= r_cand_y;
                        // A commit at a full counter ends the trace with the counter saturated.
                        if (w_step_max) begin
                            r_error <= 1'b1;
                        end else begin
                            r_step <= r_step + 8'd1;
                            if (r_last) begin
                                if (w_cand_corner) r_success <= 1'b1;
                                else               r_error   <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_tracer.sv
// tb/tb_move_tracer.sv - self-checking bench for move_tracer
module tb_move_tracer;

    logic       CLK = 1'b0;
    logic       RST, start, move_valid, move_last, map_data;
    logic       move_ready, busy, done, success, error;
    logic [1:0] move;
    logic [7:0] map_addr;
    logic [3:0] X, Y;
    logic [7:0] step_count;
    logic       maze [0:255];
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;
    assign map_data = maze[map_addr];

    move_tracer #(.N(4), .DIRECTION_SIZE(2)) dut (
        .CLK(CLK), .RST(RST), .start(start), .move_valid(move_valid), .move(move),
        .move_last(move_last), .move_ready(move_ready), .map_addr(map_addr),
        .map_data(map_data), .X(X), .Y(Y), .step_count(step_count), .busy(busy),
        .done(done), .success(success), .error(error)
    );

    typedef struct {
        bit         restart;
        logic [1:0] mv;
        bit         last;
        int         wall;
        int         ex, ey, es;
        bit         edone, esucc, eerr;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_maze();
        for (int i = 0; i < 256; i++) maze[i] = 1'b0;
    endtask

    task automatic drive_move(input logic [1:0] mv, input bit last);
        int k;
        move_valid = 1'b1;
        move       = mv;
        move_last  = last;
        k = 0;
        while (!move_ready && k < 8) begin
            tick();
            k++;
        end
        if (!move_ready) begin
            checks++;
            errors++;
            $display("FAIL move_ready timeout: got 0 expected 1");
        end
        tick();
        move_valid = 1'b0;
        move_last  = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int ex, input int ey, input int es,
                              input bit d, input bit s, input bit e);
        chk({tag, " X"}, X, ex);
        chk({tag, " Y"}, Y, ey);
        chk({tag, " step_count"}, step_count, es);
        chk({tag, " done"}, done, d);
        chk({tag, " success"}, success, s);
        chk({tag, " error"}, error, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mx, my, ms, cx, cy, n, r;
        bit mdone, msucc, merr, off, last;
        logic [1:0] mv;

        RST = 1'b1; start = 1'b0; move_valid = 1'b0; move = 2'b00; move_last = 1'b0;
        clear_maze();
        tick();
        tick();
        RST = 1'b0;

        chk_status("reset", 0, 0, 0, 0, 0, 0);
        chk("reset busy", busy, 0);
        chk("reset move_ready", move_ready, 0);
        chk("reset map_addr", map_addr, 0);

        vecs[0] = '{1, 2'b00, 0, -1, 1, 0, 1, 0, 0, 0};
        vecs[1] = '{0, 2'b01, 0, -1, 1, 1, 2, 0, 0, 0};
        vecs[2] = '{0, 2'b10, 0, -1, 0, 1, 3, 0, 0, 0};
        vecs[3] = '{0, 2'b11, 0, -1, 0, 0, 4, 0, 0, 0};
        vecs[4] = '{0, 2'b10, 0, -1, 0, 0, 4, 1, 0, 1};
        vecs[5] = '{1, 2'b11, 0, -1, 0, 0, 0, 1, 0, 1};
        vecs[6] = '{1, 2'b00, 0,  1, 0, 0, 0, 1, 0, 1};
        vecs[7] = '{1, 2'b01, 1, -1, 0, 1, 1, 1, 0, 1};

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].restart) begin
                clear_maze();
                do_start();
            end
            if (vecs[i].wall >= 0) maze[vecs[i].wall] = 1'b1;
            drive_move(vecs[i].mv, vecs[i].last);
            if (vecs[i].wall >= 0) chk("vec map_addr in CHECK", map_addr, vecs[i].wall);
            if (vecs[i].edone && vecs[i].wall < 0 && vecs[i].es == vecs[i].ex + vecs[i].ey - 1 + 1 - vecs[i].ex - vecs[i].ey)
                chk("vec no wrapped map_addr", map_addr, 0);
            tick();
            chk_status($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].es,
                       vecs[i].edone, vecs[i].esucc, vecs[i].eerr);
        end

        // Full diagonal path on an empty map
        clear_maze();
        do_start();
        for (int j = 0; j < 15; j++) begin drive_move(2'b00, 0); tick(); end
        for (int j = 0; j < 15; j++) begin drive_move(2'b01, j == 14); tick(); end
        chk_status("full path", 15, 15, 30, 1, 1, 0);
        chk("full path busy", busy, 0);

        // Continuous move_valid: accept every other cycle, commit one cycle later
        do_reset();
        do_start();
        move_valid = 1'b1; move = 2'b00; move_last = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stream c%0d move_ready", c), move_ready, (c % 2 == 0) ? 1 : 0);
            chk($sformatf("stream c%0d X", c), X, c / 2);
            tick();
        end
        move_valid = 1'b0;

        // Reset during CHECK of move 3
        do_reset();
        do_start();
        drive_move(2'b00, 0); tick();
        drive_move(2'b01, 0); tick();
        drive_move(2'b00, 0);
        chk("mid CHECK busy", busy, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_status("rst in CHECK", 0, 0, 0, 0, 0, 0);
        chk("rst in CHECK busy", busy, 0);
        chk("rst in CHECK move_ready", move_ready, 0);

        // Reset wins over start and move_valid
        RST = 1'b1; start = 1'b1; move_valid = 1'b1;
        tick();
        RST = 1'b0; start = 1'b0; move_valid = 1'b0;
        chk("rst priority busy", busy, 0);
        chk("rst priority move_ready", move_ready, 0);

        // Path ending off the corner, start ignored mid-trace, then restart
        do_start();
        drive_move(2'b00, 0); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start ignored X", X, 1);
        chk("start ignored busy", busy, 1);
        drive_move(2'b00, 0); tick();
        drive_move(2'b00, 0); tick();
        drive_move(2'b01, 0); tick();
        drive_move(2'b01, 1); tick();
        chk_status("end at 3,2", 3, 2, 5, 1, 0, 1);
        do_start();
        chk_status("restart", 0, 0, 0, 0, 0, 0);
        chk("restart busy", busy, 1);
        chk("restart move_ready", move_ready, 1);

        // Step counter saturation
        do_reset();
        clear_maze();
        do_start();
        for (int k = 0; k < 255; k++) begin
            drive_move((k % 2 == 0) ? 2'b00 : 2'b10, 0);
            tick();
        end
        chk_status("255 steps", 1, 0, 255, 0, 0, 0);
        drive_move(2'b10, 0);
        tick();
        chk_status("256th step", 0, 0, 255, 1, 0, 1);

        // Random walks on random mazes against a rule-level model
        for (int t = 0; t < 30; t++) begin
            do_reset();
            for (int i = 0; i < 256; i++) maze[i] = ($urandom_range(0, 9) == 0);
            maze[0] = 1'b0;
            do_start();
            mx = 0; my = 0; ms = 0; mdone = 0; msucc = 0; merr = 0; n = 0;
            while (!mdone && n < 60) begin
                r    = $urandom_range(0, 7);
                mv   = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
                last = ($urandom_range(0, 24) == 0) || (mx == 15 && my == 14 && mv == 2'b01)
                       || (mx == 14 && my == 15 && mv == 2'b00);
                cx = mx + ((mv == 2'b00) ? 1 : (mv == 2'b10) ? -1 : 0);
                cy = my + ((mv == 2'b01) ? 1 : (mv == 2'b11) ? -1 : 0);
                off = (cx < 0 || cx > 15 || cy < 0 || cy > 15);
                if (off) begin
                    merr = 1; mdone = 1;
                end else if (maze[cy * 16 + cx]) begin
                    merr = 1; mdone = 1;
                end else begin
                    mx = cx; my = cy; ms++;
                    if (last) begin
                        mdone = 1;
                        if (mx == 15 && my == 15) msucc = 1;
                        else                      merr  = 1;
                    end
                end
                drive_move(mv, last);
                if (!off) chk("rand map_addr", map_addr, cy * 16 + cx);
                tick();
                chk_status($sformatf("rand t%0d n%0d", t, n), mx, my, ms, mdone, msucc, merr);
                n++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
